park_token_unit: RTL and testbench

Sequential, parametrised token engine for the parking controller. It allocates the lowest free spot on entry and issues an XOR-encrypted token for it. On exit it decrypts the presented token with a loadable key and validates the spot against an occupancy map. Repeated invalid exit tokens trigger a timed lockout. It sits between the gate/keypad front end and the spot display, and replaces purely combinational token decoding.

---
 rtl/park_token_unit.sv | 193 +++++++++++++++++++
 tb/tb_park_token_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/park_token_unit.sv
// park_token_unit
// ---------------
// Token engine for the parking controller. An entry request allocates the
// lowest free spot and issues token = spot ^ key. An exit request decrypts
// the presented token with the same key and frees the spot if it is
// occupied. MAX_FAIL consecutive invalid exit tokens put the unit into a
// LOCK state for LOCK_CYCLES cycles.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   key_load, key_in  : key register load (honoured only in IDLE)
//   entry_req         : request a spot (sampled in IDLE)
//   exit_req, token_in: request an exit with a token (sampled in IDLE,
//                       has priority over entry_req)
//   busy              : high in every state except IDLE
//   done              : one-cycle pulse in RESP
//   ok                : result of the last request (1 = success)
//   token_out         : token from the last successful entry
//   park_number       : spot of the last request (allocated or decrypted)
//   locked            : high while in LOCK
//   full, empty       : occupancy map all ones / all zeros
//   free_count        : number of free spots
//   state_dbg         : current FSM state for debug/checkers
//
// Handshake: a request is a level on entry_req/exit_req that is taken only
// on a rising edge where the unit is in IDLE (busy = 0); it is never queued.
// Completion is signalled by the single-cycle done pulse, with ok,
// park_number and token_out valid from that cycle until the next request
// overwrites them.

module park_token_unit #(
  parameter int WIDTH       = 3,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_in,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic [WIDTH-1:0] token_in,
  output logic             busy,
  output logic             done,
  output logic             ok,
  output logic [WIDTH-1:0] token_out,
  output logic [WIDTH-1:0] park_number,
  output logic             locked,
  output logic             full,
  output logic             empty,
  output logic [WIDTH:0]   free_count,
  output logic [2:0]       state_dbg
);

  localparam int NSPOTS = 2 ** WIDTH;
  localparam int FW     = $clog2(MAX_FAIL + 1);
  localparam int LW     = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ENTRY  = 3'd1,
    S_DECODE = 3'd2,
    S_CHECK  = 3'd3,
    S_RESP   = 3'd4,
    S_LOCK   = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  key_q;
  logic [WIDTH-1:0]  token_q;
  logic [NSPOTS-1:0] occ_q;
  logic [FW-1:0]     fail_q;
  logic [LW-1:0]     lock_q;
  logic              ok_q;
  logic [WIDTH-1:0]  park_q;
  logic [WIDTH-1:0]  token_out_q;

  logic [WIDTH-1:0]  free_idx;
  logic [WIDTH:0]    free_cnt;

  // Lowest free index: scan from the top so the last hit is the lowest.
  // Only meaningful when the map is not full.
  always_comb begin
    free_idx = '0;
    for (int i = NSPOTS - 1; i >= 0; i--) begin
      if (!occ_q[i]) free_idx = WIDTH'(i);
    end
  end

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < NSPOTS; i++) begin
      free_cnt = free_cnt + {{WIDTH{1'b0}}, ~occ_q[i]};
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (exit_req)       state_nxt = S_DECODE;
        else if (entry_req) state_nxt = S_ENTRY;
      end
      S_ENTRY:  state_nxt = S_RESP;
      S_DECODE: state_nxt = S_CHECK;
      S_CHECK:  state_nxt = S_RESP;
      S_RESP: begin
        if (fail_q == FW'(MAX_FAIL)) state_nxt = S_LOCK;
        else                         state_nxt = S_IDLE;
      end
      S_LOCK: begin
        if (lock_q == LW'(1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_RESP);
    locked    = (state == S_LOCK);
    state_dbg = state;
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q       <= '0;
      token_q     <= '0;
      occ_q       <= '0;
      fail_q      <= '0;
      lock_q      <= '0;
      ok_q        <= 1'b0;
      park_q      <= '0;
      token_out_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // The key is written on the same edge a request is accepted, so
          // that request already sees the new key.
          if (key_load) key_q <= key_in;
          if (exit_req) token_q <= token_in;
        end
        S_ENTRY: begin
          if (&occ_q) begin
            ok_q <= 1'b0;
          end else begin
            occ_q[free_idx] <= 1'b1;
            park_q          <= free_idx;
            token_out_q     <= free_idx ^ key_q;
            ok_q            <= 1'b1;
          end
        end
        S_DECODE: begin
          // park_q doubles as the latched decrypted spot used by CHECK.
          park_q <= token_q ^ key_q;
        end
        S_CHECK: begin
          if (occ_q[park_q]) begin
            occ_q[park_q] <= 1'b0;
            ok_q          <= 1'b1;
            fail_q        <= '0;
          end else begin
            ok_q   <= 1'b0;
            fail_q <= fail_q + FW'(1);
          end
        end
        S_RESP: begin
          if (fail_q == FW'(MAX_FAIL)) lock_q <= LW'(LOCK_CYCLES);
        end
        S_LOCK: begin
          lock_q <= lock_q - LW'(1);
          if (lock_q == LW'(1)) fail_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign ok          = ok_q;
  assign park_number = park_q;
  assign token_out   = token_out_q;
  assign full        = &occ_q;
  assign empty       = ~|occ_q;
  assign free_count  = free_cnt;

endmodule

// File: tb/tb_park_token_unit.sv
// Testbench for park_token_unit: directed scenarios followed by a random
// request mix, checked against a spot-array reference model.
module tb_park_token_unit;

  localparam int WIDTH       = 3;
  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYCLES = 16;
  localparam int NSPOTS      = 8;

  // ------------------------------------------------ clock / reset block
  logic       clk = 1'b0;
  logic       rst;
  logic       key_load, entry_req, exit_req;
  logic [2:0] key_in, token_in;
  logic       busy, done, ok, locked, full, empty;
  logic [2:0] token_out, park_number, state_dbg;
  logic [3:0] free_count;

  always #5 clk = ~clk;

  park_token_unit #(
    .WIDTH(WIDTH), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .entry_req(entry_req), .exit_req(exit_req), .token_in(token_in),
    .busy(busy), .done(done), .ok(ok), .token_out(token_out),
    .park_number(park_number), .locked(locked), .full(full),
    .empty(empty), .free_count(free_count), .state_dbg(state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ------------------------------------------------ reference model
  bit occ_m[NSPOTS];
  int key_m, fail_m, park_m, tok_m, ok_m;

  // scoreboard: expected {ok, park_number, token_out} per request
  logic [6:0] exp_q[$];

  function automatic int model_free();
    int n = 0;
    for (int i = 0; i < NSPOTS; i++) if (!occ_m[i]) n++;
    return n;
  endfunction

  function automatic int model_lowest();
    for (int i = 0; i < NSPOTS; i++) if (!occ_m[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSPOTS; i++) occ_m[i] = 1'b0;
    key_m = 0; fail_m = 0; park_m = 0; tok_m = 0; ok_m = 0;
    exp_q.delete();
  endtask

  // ------------------------------------------------ checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_occupancy(input string tag);
    int nf;
    nf = model_free();
    check({tag, "_free_count"}, 32'(free_count), 32'(nf));
    check({tag, "_full"}, 32'(full), 32'(nf == 0));
    check({tag, "_empty"}, 32'(empty), 32'(nf == NSPOTS));
  endtask

  task automatic check_resp(input string tag);
    logic [6:0] e;
    check({tag, "_done"}, 32'(done), 32'd1);
    e = exp_q.pop_front();
    check({tag, "_ok"}, 32'(ok), 32'(e[6]));
    check({tag, "_park"}, 32'(park_number), 32'(e[5:3]));
    check({tag, "_token"}, 32'(token_out), 32'(e[2:0]));
    check_occupancy(tag);
  endtask

  // ------------------------------------------------ driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    key_load = 1'b0; entry_req = 1'b0; exit_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Lockout window: entered one cycle after RESP. Requests and key loads
  // are thrown at the unit throughout and must be ignored.
  task automatic lock_window();
    for (int c = 0; c < LOCK_CYCLES; c++) begin
      check("lock_locked", 32'(locked), 32'd1);
      check("lock_busy", 32'(busy), 32'd1);
      check("lock_done", 32'(done), 32'd0);
      entry_req = 1'b1;
      exit_req  = 1'($urandom_range(0, 1));
      token_in  = 3'($urandom_range(0, 7));
      key_load  = 1'($urandom_range(0, 1));
      key_in    = 3'($urandom_range(0, 7));
      tick();
    end
    idle_inputs();
    fail_m = 0;
    check("lock_release", 32'(locked), 32'd0);
    check("lock_idle", 32'(busy), 32'd0);
    check_occupancy("lock_after");
  endtask

  // Called with the DUT in IDLE, #1 after an edge.
  task automatic do_entry(input bit with_key, input logic [2:0] k);
    int i;
    entry_req = 1'b1;
    key_load  = with_key;
    key_in    = k;
    if (with_key) key_m = k;
    i = model_lowest();
    if (i < 0) begin
      ok_m = 0;
    end else begin
      occ_m[i] = 1'b1;
      park_m = i;
      tok_m  = i ^ key_m;
      ok_m   = 1;
    end
    exp_q.push_back({ok_m[0], park_m[2:0], tok_m[2:0]});
    tick();
    idle_inputs();
    check("entry_busy", 32'(busy), 32'd1);
    check("entry_done_early", 32'(done), 32'd0);
    tick();
    check_resp("entry");
    tick();
    check("entry_idle", 32'(busy), 32'd0);
    check("entry_done_after", 32'(done), 32'd0);
  endtask

  task automatic do_exit(input logic [2:0] tok, input bit with_key,
                         input logic [2:0] k, input bit also_entry);
    int spot;
    exit_req  = 1'b1;
    token_in  = tok;
    entry_req = also_entry;
    key_load  = with_key;
    key_in    = k;
    if (with_key) key_m = k;
    spot   = tok ^ key_m;
    park_m = spot;
    if (occ_m[spot]) begin
      occ_m[spot] = 1'b0;
      ok_m   = 1;
      fail_m = 0;
    end else begin
      ok_m   = 0;
      fail_m = fail_m + 1;
    end
    exp_q.push_back({ok_m[0], park_m[2:0], tok_m[2:0]});
    tick();
    idle_inputs();
    check("exit_busy1", 32'(busy), 32'd1);
    check("exit_done1", 32'(done), 32'd0);
    tick();
    check("exit_busy2", 32'(busy), 32'd1);
    check("exit_done2", 32'(done), 32'd0);
    tick();
    check_resp("exit");
    tick();
    if (fail_m == MAX_FAIL) begin
      lock_window();
    end else begin
      check("exit_idle", 32'(busy), 32'd0);
      check("exit_unlocked", 32'(locked), 32'd0);
    end
  endtask

  // ------------------------------------------------ stimulus
  initial begin
    logic [2:0] k, tok;
    bit         wk, ae;
    int         occ_list[$];

    idle_inputs();
    rst = 1'b1; key_in = '0; token_in = '0;
    model_reset();

    // Reset and defaults
    do_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ok", 32'(ok), 32'd0);
    check("rst_token", 32'(token_out), 32'd0);
    check("rst_park", 32'(park_number), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_free_count", 32'(free_count), 32'd8);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);

    key_load = 1'b1; key_in = 3'b101; key_m = 5;
    tick();
    idle_inputs();
    check("keyload_busy", 32'(busy), 32'd0);
    check("keyload_empty", 32'(empty), 32'd1);

    // Round trip
    do_entry(1'b0, 3'b000);
    do_exit(3'b101, 1'b0, 3'b000, 1'b0);

    // Fill and overflow
    for (int n = 0; n < NSPOTS; n++) do_entry(1'b0, 3'b000);
    check("fill_full", 32'(full), 32'd1);
    do_entry(1'b0, 3'b000);

    // Simultaneous entry + exit: only the exit is serviced
    do_exit(3'b011 ^ 3'b101, 1'b0, 3'b000, 1'b1);

    // Lockout
    do_reset();
    do_entry(1'b1, 3'b101);
    for (int n = 0; n < MAX_FAIL; n++) do_exit(3'b100, 1'b0, 3'b000, 1'b0);
    do_entry(1'b0, 3'b000);

    // Random mix
    for (int n = 0; n < 250; n++) begin
      wk = ($urandom_range(0, 3) == 0);
      k  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 45) begin
        do_entry(wk, k);
      end else begin
        occ_list.delete();
        for (int s = 0; s < NSPOTS; s++) if (occ_m[s]) occ_list.push_back(s);
        if (occ_list.size() > 0 && $urandom_range(0, 1) == 1)
          tok = 3'(occ_list[$urandom_range(0, occ_list.size() - 1)]) ^ (wk ? k : 3'(key_m));
        else
          tok = 3'($urandom_range(0, 7));
        ae = ($urandom_range(0, 7) == 0);
        do_exit(tok, wk, k, ae);
      end
    end

    // Reset during CHECK of an exit
    do_reset();
    do_entry(1'b1, 3'b101);
    exit_req = 1'b1; token_in = 3'b101;
    tick();
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ok", 32'(ok), 32'd0);
    check("midrst_park", 32'(park_number), 32'd0);
    check("midrst_token", 32'(token_out), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);
    check_occupancy("midrst");
    tick();
    check("midrst_no_late_done", 32'(done), 32'd0);
    // key must be back to 0: spot 1 then yields token 1
    do_entry(1'b0, 3'b000);
    do_entry(1'b0, 3'b000);

    // ------------------------------------------------ final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
